// File: rtl/mips_define.sv
// Shared definitions for the MIPS pipeline front end.
// Next-PC select codes, the NOP word, fetch FSM states and IF/ID bundle.
package mips_define;

  localparam logic [2:0] PC_NEXT     = 3'd0;
  localparam logic [2:0] PC_JUMP     = 3'd1;
  localparam logic [2:0] PC_BRANCH   = 3'd2;
  localparam logic [2:0] PC_FWD_DATA = 3'd3;

  localparam logic [31:0] NOP = 32'h0000_0000;

  typedef enum logic {
    RUN     = 1'b0,
    PENDING = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        valid;
  } if_id_t;

endpackage

// File: rtl/if_next_pc.sv
// Redirect detection and jump/branch/jr target for the instruction in ID.
// In: id_valid, id_en, pc_src, pc_id, inst, rs_fwd_data. Out: redirect, target, misaligned.
module if_next_pc
  import mips_define::*;
(
  input  logic        id_valid,
  input  logic        id_en,
  input  logic [2:0]  pc_src,
  input  logic [31:0] pc_id,
  input  logic [31:0] inst,
  input  logic [31:0] rs_fwd_data,
  output logic        redirect,
  output logic [31:0] target,
  output logic        misaligned
);

  logic [31:0] pc4;
  logic [31:0] br_off;
  logic        live;

  assign pc4    = pc_id + 32'd4;
  assign br_off = {{14{inst[15]}}, inst[15:0], 2'b00};
  assign live   = id_valid & id_en;

  always_comb begin
    redirect   = 1'b0;
    target     = pc4;
    misaligned = 1'b0;
    unique case (1'b1)
      pc_src == PC_JUMP: begin
        redirect = live;
        target   = {pc4[31:28], inst[25:0], 2'b00};
      end
      pc_src == PC_BRANCH: begin
        redirect = live;
        target   = pc4 + br_off;
      end
      pc_src == PC_FWD_DATA: begin
        redirect   = live;
        target     = {rs_fwd_data[31:2], 2'b00};
        misaligned = live & (|rs_fwd_data[1:0]);
      end
      default: begin
        redirect = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: PC, req/ack imem port, IF/ID register.
// Delay-slot aware redirect FSM (RUN/PENDING), stall counter, jr misalign pulse.
module if_stage
  import mips_define::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_rst,
  input  logic        if_en,
  input  logic        id_rst,
  input  logic        id_en,
  input  logic [2:0]  pc_src,
  input  logic [31:0] rs_fwd_data,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic [31:0] pc_id,
  output logic        id_valid,
  output logic        if_valid,
  output logic        fetch_misaligned,
  output logic [31:0] stall_cycles
);

  fetch_state_t state;
  if_id_t       id_q;
  logic [31:0]  pc_if;
  logic [31:0]  pend_pc;
  logic [31:0]  target;
  logic         accept;
  logic         redirect;
  logic         mis;

  assign imem_req  = if_en & if_valid;
  assign imem_addr = pc_if;
  assign accept    = imem_req & imem_ack;
  assign inst      = id_q.inst;
  assign pc_id     = id_q.pc;
  assign id_valid  = id_q.valid;

  if_next_pc u_next_pc (
    .id_valid    (id_q.valid),
    .id_en       (id_en),
    .pc_src      (pc_src),
    .pc_id       (id_q.pc),
    .inst        (id_q.inst),
    .rs_fwd_data (rs_fwd_data),
    .redirect    (redirect),
    .target      (target),
    .misaligned  (mis)
  );

  // Survives if_rst; only the global reset clears it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cycles <= '0;
    end else if (imem_req && !imem_ack && !(&stall_cycles)) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || if_rst) begin
      pc_if            <= RESET_PC;
      pend_pc          <= RESET_PC;
      state            <= RUN;
      id_q             <= '0;
      if_valid         <= 1'b0;
      fetch_misaligned <= 1'b0;
    end else begin
      if_valid         <= 1'b1;
      fetch_misaligned <= mis;

      if (id_rst) begin
        id_q.inst  <= NOP;
        id_q.valid <= 1'b0;
      end else if (id_en) begin
        if (accept) begin
          id_q.inst  <= imem_rdata;
          id_q.pc    <= pc_if;
          id_q.valid <= 1'b1;
        end else begin
          id_q.inst  <= NOP;
          id_q.valid <= 1'b0;
        end
      end

      // A redirect without a fetched delay slot parks the target
      // until the slot word is finally acknowledged.
      if (if_en) begin
        unique case (state)
          RUN: begin
            if (redirect && accept) begin
              pc_if <= target;
            end else if (redirect) begin
              pend_pc <= target;
              state   <= PENDING;
            end else if (accept) begin
              pc_if <= pc_if + 32'd4;
            end
          end
          PENDING: begin
            if (accept) begin
              pc_if <= pend_pc;
              state <= RUN;
            end
          end
          default: state <= RUN;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: directed fetch, branch, jump, jr,
// load-stall and mid-operation reset scenarios.
module tb_if_stage;
  import mips_define::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_rst;
  logic        if_en;
  logic        id_rst;
  logic        id_en;
  logic [2:0]  pc_src;
  logic [31:0] rs_fwd_data;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] inst;
  logic [31:0] pc_id;
  logic        id_valid;
  logic        if_valid;
  logic        fetch_misaligned;
  logic [31:0] stall_cycles;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] sb[$];

  if_stage #(.RESET_PC(32'h0)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .if_rst           (if_rst),
    .if_en            (if_en),
    .id_rst           (id_rst),
    .id_en            (id_en),
    .pc_src           (pc_src),
    .rs_fwd_data      (rs_fwd_data),
    .imem_req         (imem_req),
    .imem_addr        (imem_addr),
    .imem_ack         (imem_ack),
    .imem_rdata       (imem_rdata),
    .inst             (inst),
    .pc_id            (pc_id),
    .id_valid         (id_valid),
    .if_valid         (if_valid),
    .fetch_misaligned (fetch_misaligned),
    .stall_cycles     (stall_cycles)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0010: mem_word = 32'h1000_0003;
      32'h0040_0008: mem_word = 32'h0810_0010;
      default:       mem_word = a;
    endcase
  endfunction

  always_comb imem_rdata = mem_word(imem_addr);

  always @(negedge clk) begin
    if (rst_n && dut.state == PENDING && id_valid && id_en && pc_src != PC_NEXT) begin
      miscompares++;
      $display("FAIL pending_redirect pc_id %h pc_src %0d", pc_id, pc_src);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [31:0] x;
    rst_n = 1'b0; if_rst = 1'b0; id_rst = 1'b0;
    if_en = 1'b1; id_en = 1'b1; pc_src = PC_NEXT;
    rs_fwd_data = '0; imem_ack = 1'b1;
    step();
    step();
    rst_n = 1'b1;
    vectors++;
    if (id_valid !== 1'b0 || inst !== 32'h0 || pc_id !== 32'h0) begin
      miscompares++;
      $display("FAIL rst_id got v%b i%h p%h want 0", id_valid, inst, pc_id);
    end
    vectors++;
    if (if_valid !== 1'b0 || imem_req !== 1'b0 || stall_cycles !== 32'h0) begin
      miscompares++;
      $display("FAIL rst_if got v%b r%b s%0d want 0", if_valid, imem_req, stall_cycles);
    end
    step();
    vectors++;
    if (if_valid !== 1'b1 || imem_req !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_release got v%b r%b want 1", if_valid, imem_req);
    end
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if (imem_addr !== 32'(k * 4)) begin
        miscompares++;
        $display("FAIL rst_addr got %h want %h", imem_addr, 32'(k * 4));
      end
      sb.push_back(32'(k * 4));
      step();
      x = sb.pop_front();
      vectors++;
      if (pc_id !== x || inst !== mem_word(x) || id_valid !== 1'b1) begin
        miscompares++;
        $display("FAIL rst_id_seq got %h/%h/%b want %h/%h/1", pc_id, inst, id_valid, x, mem_word(x));
      end
    end
  endtask

  task automatic warm(input logic [31:0] stop);
    logic [31:0] x;
    imem_ack = 1'b1; pc_src = PC_NEXT;
    if_rst = 1'b1;
    step();
    if_rst = 1'b0;
    step();
    for (logic [31:0] e = 32'h0; e < stop; e += 32'd4) begin
      vectors++;
      if (imem_addr !== e) begin
        miscompares++;
        $display("FAIL warm_addr got %h want %h", imem_addr, e);
      end
      sb.push_back(e);
      step();
      x = sb.pop_front();
      vectors++;
      if (pc_id !== x || id_valid !== 1'b1) begin
        miscompares++;
        $display("FAIL warm_id got %h/%b want %h/1", pc_id, id_valid, x);
      end
    end
  endtask

  task automatic test_branch_fast();
    logic [31:0] exp_a[3] = '{32'h10, 32'h14, 32'h20};
    logic [2:0]  src[3]   = '{PC_NEXT, PC_BRANCH, PC_NEXT};
    logic [31:0] x;
    for (int k = 0; k < 3; k++) begin
      pc_src = src[k];
      vectors++;
      if (imem_addr !== exp_a[k]) begin
        miscompares++;
        $display("FAIL br_fast_addr got %h want %h", imem_addr, exp_a[k]);
      end
      sb.push_back(exp_a[k]);
      step();
      pc_src = PC_NEXT;
      x = sb.pop_front();
      vectors++;
      if (pc_id !== x || inst !== mem_word(x) || id_valid !== 1'b1) begin
        miscompares++;
        $display("FAIL br_fast_id got %h/%h/%b want %h/%h/1", pc_id, inst, id_valid, x, mem_word(x));
      end
    end
    vectors++;
    if (imem_addr !== 32'h24) begin
      miscompares++;
      $display("FAIL br_fast_after got %h want %h", imem_addr, 32'h24);
    end
  endtask

  task automatic test_branch_slow();
    logic [31:0] s0;
    logic [31:0] x;
    warm(32'h10);
    sb.push_back(32'h10);
    step();
    x = sb.pop_front();
    vectors++;
    if (pc_id !== x || inst !== 32'h1000_0003) begin
      miscompares++;
      $display("FAIL br_slow_beq got %h/%h want %h/10000003", pc_id, inst, x);
    end
    s0 = stall_cycles;
    pc_src = PC_BRANCH;
    imem_ack = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      pc_src = PC_NEXT;
      vectors++;
      if (id_valid !== 1'b0 || imem_addr !== 32'h14 || imem_req !== 1'b1) begin
        miscompares++;
        $display("FAIL br_slow_wait got v%b a%h r%b want 0/14/1", id_valid, imem_addr, imem_req);
      end
    end
    vectors++;
    if (stall_cycles !== s0 + 32'd3) begin
      miscompares++;
      $display("FAIL br_slow_stall got %0d want %0d", stall_cycles, s0 + 32'd3);
    end
    imem_ack = 1'b1;
    sb.push_back(32'h14);
    step();
    x = sb.pop_front();
    vectors++;
    if (pc_id !== x || id_valid !== 1'b1 || imem_addr !== 32'h20) begin
      miscompares++;
      $display("FAIL br_slow_ds got %h/%b a%h want %h/1 a20", pc_id, id_valid, imem_addr, x);
    end
    sb.push_back(32'h20);
    step();
    x = sb.pop_front();
    vectors++;
    if (pc_id !== x || imem_addr !== 32'h24) begin
      miscompares++;
      $display("FAIL br_slow_tgt got %h a%h want %h a24", pc_id, imem_addr, x);
    end
  endtask

  task automatic test_jump_jr();
    logic [31:0] x;
    pc_src = PC_FWD_DATA;
    rs_fwd_data = 32'h0000_0103;
    sb.push_back(32'h24);
    step();
    pc_src = PC_NEXT;
    x = sb.pop_front();
    vectors++;
    if (pc_id !== x || imem_addr !== 32'h100 || fetch_misaligned !== 1'b1) begin
      miscompares++;
      $display("FAIL jr_mis got %h a%h m%b want %h a100 m1", pc_id, imem_addr, fetch_misaligned, x);
    end
    sb.push_back(32'h100);
    step();
    x = sb.pop_front();
    vectors++;
    if (pc_id !== x || fetch_misaligned !== 1'b0) begin
      miscompares++;
      $display("FAIL jr_pulse got %h m%b want %h m0", pc_id, fetch_misaligned, x);
    end
    pc_src = PC_FWD_DATA;
    rs_fwd_data = 32'h0040_0000;
    sb.push_back(32'h104);
    step();
    pc_src = PC_NEXT;
    x = sb.pop_front();
    vectors++;
    if (pc_id !== x || imem_addr !== 32'h0040_0000 || fetch_misaligned !== 1'b0) begin
      miscompares++;
      $display("FAIL jr_align got %h a%h m%b want %h a400000 m0", pc_id, imem_addr, fetch_misaligned, x);
    end
    for (int k = 0; k < 3; k++) begin
      sb.push_back(32'h0040_0000 + 32'(k * 4));
      step();
      x = sb.pop_front();
      vectors++;
      if (pc_id !== x || inst !== mem_word(x)) begin
        miscompares++;
        $display("FAIL j_walk got %h/%h want %h/%h", pc_id, inst, x, mem_word(x));
      end
    end
    pc_src = PC_JUMP;
    sb.push_back(32'h0040_000C);
    step();
    pc_src = PC_NEXT;
    x = sb.pop_front();
    vectors++;
    if (pc_id !== x || imem_addr !== 32'h0040_0040) begin
      miscompares++;
      $display("FAIL j_target got %h a%h want %h a00400040", pc_id, imem_addr, x);
    end
  endtask

  task automatic test_load_stall();
    logic [31:0] s0;
    logic [31:0] x;
    s0 = stall_cycles;
    if_en = 1'b0; id_en = 1'b0; imem_ack = 1'b0;
    for (int k = 0; k < 2; k++) begin
      #1;
      vectors++;
      if (imem_req !== 1'b0) begin
        miscompares++;
        $display("FAIL stall_req got %b want 0", imem_req);
      end
      step();
      vectors++;
      if (pc_id !== 32'h0040_000C || inst !== 32'h0040_000C ||
          imem_addr !== 32'h0040_0040 || id_valid !== 1'b1) begin
        miscompares++;
        $display("FAIL stall_hold got %h/%h a%h want 0040000c a00400040", pc_id, inst, imem_addr);
      end
    end
    vectors++;
    if (stall_cycles !== s0) begin
      miscompares++;
      $display("FAIL stall_count got %0d want %0d", stall_cycles, s0);
    end
    if_en = 1'b1; id_en = 1'b1; imem_ack = 1'b1;
    sb.push_back(32'h0040_0040);
    step();
    x = sb.pop_front();
    vectors++;
    if (pc_id !== x || imem_addr !== 32'h0040_0044) begin
      miscompares++;
      $display("FAIL stall_resume got %h a%h want %h a00400044", pc_id, imem_addr, x);
    end
  endtask

  task automatic test_mid_reset();
    logic [31:0] x;
    pc_src = PC_BRANCH;
    imem_ack = 1'b0;
    step();
    pc_src = PC_NEXT;
    vectors++;
    if (id_valid !== 1'b0 || imem_addr !== 32'h0040_0044) begin
      miscompares++;
      $display("FAIL pend_enter got v%b a%h want 0 a00400044", id_valid, imem_addr);
    end
    if_rst = 1'b1;
    step();
    if_rst = 1'b0;
    vectors++;
    if (imem_addr !== 32'h0 || id_valid !== 1'b0 || if_valid !== 1'b0 || imem_req !== 1'b0) begin
      miscompares++;
      $display("FAIL ifrst got a%h v%b iv%b r%b want 0", imem_addr, id_valid, if_valid, imem_req);
    end
    imem_ack = 1'b1;
    step();
    vectors++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      miscompares++;
      $display("FAIL ifrst_release got r%b a%h want 1 a0", imem_req, imem_addr);
    end
    sb.push_back(32'h0);
    step();
    x = sb.pop_front();
    vectors++;
    if (pc_id !== x || id_valid !== 1'b1 || imem_addr !== 32'h4) begin
      miscompares++;
      $display("FAIL ifrst_run got %h/%b a%h want %h/1 a4", pc_id, id_valid, imem_addr, x);
    end
    id_rst = 1'b1;
    step();
    id_rst = 1'b0;
    vectors++;
    if (inst !== 32'h0 || id_valid !== 1'b0 || imem_addr !== 32'h8) begin
      miscompares++;
      $display("FAIL idrst got %h/%b a%h want 0/0 a8", inst, id_valid, imem_addr);
    end
    sb.push_back(32'h8);
    step();
    x = sb.pop_front();
    vectors++;
    if (pc_id !== x || id_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL idrst_after got %h/%b want %h/1", pc_id, id_valid, x);
    end
    pc_src = PC_FWD_DATA;
    rs_fwd_data = 32'hFFFF_FFFC;
    sb.push_back(32'hC);
    step();
    pc_src = PC_NEXT;
    x = sb.pop_front();
    vectors++;
    if (pc_id !== x || imem_addr !== 32'hFFFF_FFFC) begin
      miscompares++;
      $display("FAIL wrap_jr got %h a%h want %h afffffffc", pc_id, imem_addr, x);
    end
    sb.push_back(32'hFFFF_FFFC);
    step();
    x = sb.pop_front();
    vectors++;
    if (pc_id !== x || imem_addr !== 32'h0) begin
      miscompares++;
      $display("FAIL wrap_pc got %h a%h want %h a0", pc_id, imem_addr, x);
    end
  endtask

  initial begin
    test_reset();
    test_branch_fast();
    test_branch_slow();
    test_jump_jr();
    test_load_stall();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
